// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and byte-lane helpers for the unified MIPS memory
package mips_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } MEM_STATE;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int LANES     = WORD_W / BYTE_W;
    localparam int LANE0_LSB = 0;
    localparam int LANE1_LSB = 8;
    localparam int LANE2_LSB = 16;
    localparam int LANE3_LSB = 24;

    // Little-endian byte placement: lane k occupies bits [8k+7:8k].
    function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                     input logic [BYTE_W-1:0] b,
                                                     input logic [1:0]        lane);
        logic [WORD_W-1:0] r;
        r = word;
        r[int'(lane)*BYTE_W +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mips_memory_if.sv
// rtl/mips_memory_if.sv - core fetch/load-store and program-loader signals of the memory
interface mips_memory_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic [31:0] data_addr;
    logic        data_rd_wr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        cpu_reset;
    logic        load_start;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_error;

    modport master (
        output instr_addr, data_addr, data_rd_wr, data_out,
        output load_start, load_valid, load_byte, load_last,
        input  instr_in, data_in, cpu_reset, load_ready, load_error
    );

    modport slave (
        input  instr_addr, data_addr, data_rd_wr, data_out,
        input  load_start, load_valid, load_byte, load_last,
        output instr_in, data_in, cpu_reset, load_ready, load_error
    );
endinterface

// File: rtl/mips_ram.sv
// rtl/mips_ram.sv - DEPTHx32 dual-port RAM, one read/write port and one read port, read-first
module mips_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [31:0]   wdata_a,
    output logic [31:0]   rdata_a,
    input  logic [AW-1:0] addr_b,
    output logic [31:0]   rdata_b
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_a_d, rdata_a_q;
    logic [31:0] rdata_b_d, rdata_b_q;

    // Array lookups feeding the output registers.
    always_comb begin
        rdata_a_d = mem[addr_a];
        rdata_b_d = mem[addr_b];
    end

    // Array write; no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
    end

    // Registered reads sample the pre-write contents (read-first on both ports).
    always_ff @(posedge clk) begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/mips_memory.sv
// rtl/mips_memory.sv - unified instruction/data memory with byte-stream boot loader
import mips_pkg::*;

module mips_memory #(
    parameter int DEPTH     = 1024,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    mips_memory_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam MEM_STATE RESET_STATE = BOOT_LOAD ? LOAD : RUN;

    MEM_STATE    state_q, state_d;
    logic [AW:0] waddr_q, waddr_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic        err_q, err_d;
    logic        run_first_q, run_first_d;
    logic        instr_ok_q, instr_ok_d;
    logic        data_ok_q, data_ok_d;

    logic        accept;
    logic        ld_we;
    logic [31:0] ld_word;
    logic        instr_in_range, data_in_range;
    logic        ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata_a, ram_rdata_b;
    logic        unused_addr_bits;

    assign instr_in_range   = (bus.instr_addr[31:AW+2] == '0);
    assign data_in_range    = (bus.data_addr[31:AW+2] == '0);
    assign unused_addr_bits = ^{bus.instr_addr[1:0], bus.data_addr[1:0]};

    // State and loader counters; the array itself is never cleared here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            waddr_q     <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            err_q       <= 1'b0;
            run_first_q <= 1'b0;
            instr_ok_q  <= 1'b0;
            data_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            err_q       <= err_d;
            run_first_q <= run_first_d;
            instr_ok_q  <= instr_ok_d;
            data_ok_q   <= data_ok_d;
        end
    end

    // Next state: restart on load_start, otherwise assemble bytes and commit words.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        err_d   = err_q;
        ld_we   = 1'b0;
        accept  = (state_q == LOAD) && bus.load_valid;
        ld_word = place_byte(asm_q, bus.load_byte, bcnt_q);
        if (bus.load_start) begin
            state_d = LOAD;
            waddr_d = '0;
            bcnt_d  = '0;
            asm_d   = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (bcnt_q == 2'd3 || bus.load_last) begin
                // Word complete (or image ended): commit unless past the end.
                if (waddr_q[AW]) begin
                    err_d = 1'b1;
                end else begin
                    ld_we   = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                end
                asm_d  = '0;
                bcnt_d = '0;
            end else begin
                if (waddr_q[AW]) begin
                    err_d = 1'b1;
                end
                asm_d  = ld_word;
                bcnt_d = bcnt_q + 1'b1;
            end
            if (bus.load_last) begin
                state_d = RUN;
            end
        end
    end

    // Outputs: RAM port sharing, read gating and core reset.
    always_comb begin
        run_first_d = (state_q == LOAD) && (state_d == RUN);
        instr_ok_d  = (state_q == RUN) && (state_d == RUN) && instr_in_range;
        data_ok_d   = (state_q == RUN) && (state_d == RUN) && data_in_range;
        if (state_q == LOAD) begin
            ram_we    = ld_we;
            ram_addr  = waddr_q[AW-1:0];
            ram_wdata = ld_word;
        end else begin
            ram_we    = !bus.data_rd_wr && data_in_range;
            ram_addr  = bus.data_addr[AW+1:2];
            ram_wdata = bus.data_out;
        end
        bus.load_ready = (state_q == LOAD);
        bus.cpu_reset  = (state_q == LOAD) || run_first_q;
        bus.load_error = err_q;
        bus.instr_in   = instr_ok_q ? ram_rdata_b : 32'h0;
        bus.data_in    = data_ok_q  ? ram_rdata_a : 32'h0;
    end

    mips_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_a    (ram_we),
        .addr_a  (ram_addr),
        .wdata_a (ram_wdata),
        .rdata_a (ram_rdata_a),
        .addr_b  (bus.instr_addr[AW+1:2]),
        .rdata_b (ram_rdata_b)
    );

endmodule

// File: tb/tb_mips_memory.sv
// tb/tb_mips_memory.sv - directed self-checking bench for mips_memory
module tb_mips_memory;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mips_memory_if bus();

    mips_memory #(
        .DEPTH     (1024),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send_byte(w[7:0],   1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[31:24], last);
    endtask

    task automatic read_both(input logic [31:0] iaddr, input logic [31:0] daddr);
        bus.instr_addr = iaddr;
        bus.data_addr  = daddr;
        bus.data_rd_wr = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_data(input logic [31:0] daddr, input logic [31:0] d);
        bus.data_addr  = daddr;
        bus.data_out   = d;
        bus.data_rd_wr = 1'b0;
        @(negedge clk);
        bus.data_rd_wr = 1'b1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        bus.instr_addr   = 32'h0;
        bus.data_addr    = 32'h0;
        bus.data_rd_wr   = 1'b1;
        bus.data_out     = 32'h0;
        bus.load_start   = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_byte    = 8'h0;
        bus.load_last    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_instr_in",   bus.instr_in,   32'h0);
        chk("rst_data_in",    bus.data_in,    32'h0);
        chk("rst_load_error", {31'b0, bus.load_error}, 32'h0);
        chk("rst_cpu_reset",  {31'b0, bus.cpu_reset},  32'h1);
        chk("rst_load_ready", {31'b0, bus.load_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Boot image: one full word and a two-byte tail.
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b1);
        chk("boot_cpu_reset_hold", {31'b0, bus.cpu_reset},  32'h1);
        chk("boot_load_ready_off", {31'b0, bus.load_ready}, 32'h0);
        chk("boot_instr_zero",     bus.instr_in, 32'h0);
        @(negedge clk);
        chk("boot_cpu_reset_fall", {31'b0, bus.cpu_reset},  32'h0);

        read_both(32'h0, 32'h4);
        chk("boot_mem0_instr", bus.instr_in, 32'h12345678);
        chk("boot_mem1_data",  bus.data_in,  32'h0000BEEF);

        // Core store then loads at aligned and unaligned byte addresses.
        write_data(32'h10, 32'hCAFEF00D);
        read_both(32'h0, 32'h10);
        chk("run_rd_0x10", bus.data_in, 32'hCAFEF00D);
        read_both(32'h0, 32'h13);
        chk("run_rd_0x13", bus.data_in, 32'hCAFEF00D);

        // Read-during-write on the same word from both ports.
        write_data(32'h20, 32'hAAAA5555);
        bus.instr_addr = 32'h20;
        write_data(32'h20, 32'h00000001);
        chk("rdw_data_old",  bus.data_in,  32'hAAAA5555);
        chk("rdw_instr_old", bus.instr_in, 32'hAAAA5555);
        read_both(32'h20, 32'h20);
        chk("rdw_data_new",  bus.data_in,  32'h00000001);
        chk("rdw_instr_new", bus.instr_in, 32'h00000001);

        // Out-of-range reads return 0; writes are dropped, not aliased.
        read_both(32'h1000, 32'h1000);
        chk("oor_data_rd",  bus.data_in,  32'h0);
        chk("oor_instr_rd", bus.instr_in, 32'h0);
        write_data(32'h1000, 32'hDEADBEEF);
        read_both(32'hFFC, 32'h0);
        chk("oor_mem0_intact", bus.data_in, 32'h12345678);

        // load_start with a simultaneous valid byte: the byte is dropped.
        bus.load_valid = 1'b1;
        bus.load_byte  = 8'h99;
        pulse_start();
        bus.load_valid = 1'b0;
        chk("start_cpu_reset",  {31'b0, bus.cpu_reset},  32'h1);
        chk("start_load_ready", {31'b0, bus.load_ready}, 32'h1);
        chk("start_instr_zero", bus.instr_in, 32'h0);
        send_word(32'h44332211, 1'b0);
        send_byte(8'h55, 1'b1);
        @(negedge clk);
        read_both(32'h4, 32'h0);
        chk("drop_mem0", bus.data_in,  32'h44332211);
        chk("drop_mem1", bus.instr_in, 32'h00000055);

        // Reset mid-load: counters restart, array content kept.
        pulse_start();
        send_word(32'hA4A3A2A1, 1'b0);
        send_byte(8'hB1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_load_error", {31'b0, bus.load_error}, 32'h0);
        chk("midrst_cpu_reset",  {31'b0, bus.cpu_reset},  32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(32'hC4C3C2C1, 1'b1);
        @(negedge clk);
        read_both(32'h4, 32'h0);
        chk("midrst_mem0", bus.data_in,  32'hC4C3C2C1);
        chk("midrst_mem1", bus.instr_in, 32'h00000055);

        // Overflow: DEPTH+1 words, the last one must be discarded.
        pulse_start();
        for (int i = 0; i < 1024; i++) begin
            w = 32'h5A000000 | i;
            send_word(w, 1'b0);
        end
        chk("ovf_no_error_yet", {31'b0, bus.load_error}, 32'h0);
        send_word(32'hFFFFFFFF, 1'b1);
        chk("ovf_load_error", {31'b0, bus.load_error}, 32'h1);
        @(negedge clk);
        read_both(32'hFFC, 32'h0);
        chk("ovf_mem0",    bus.data_in,  32'h5A000000);
        chk("ovf_mem1023", bus.instr_in, 32'h5A0003FF);
        chk("ovf_error_sticky", {31'b0, bus.load_error}, 32'h1);
        pulse_start();
        chk("ovf_clear_error", {31'b0, bus.load_error}, 32'h0);
        chk("ovf_cpu_reset",   {31'b0, bus.cpu_reset},  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_memory.md
# mips_memory

Unified instruction/data memory for the non-pipelined MIPS core, with a built-in program loader. It serves the core's instruction fetch port and data load/store port from one word array, and consumes the core's `instr_addr`, `data_addr`, `data_rd_wr` and `data_out` outputs. A byte-stream loader fills the array while holding the core in reset, then releases it.

## Interface
- `DEPTH`, 1024: number of 32-bit words. Must be a power of 2.
- `BOOT_LOAD`, 1:
  - 1: come out of reset in LOAD.
  - 0: come out of reset in RUN. Array content is undefined unless preloaded by simulation.

Ports:
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `instr_addr` in 32: byte address of instruction fetch, from the core.
- `instr_in` out 32: fetched instruction word, to the core.
- `data_addr` in 32: byte address of data access, from the core.
- `data_rd_wr` in 1: 1 = read, 0 = write.
- `data_out` in 32: store data from the core.
- `data_in` out 32: load data, to the core.
- `cpu_reset` out 1: active-high reset for the core.
- `load_start` in 1: single-cycle pulse; restart program load.
- `load_valid` in 1: load byte valid.
- `load_ready` out 1: loader accepts a byte.
- `load_byte` in 8: program byte, little-endian within each word.
- `load_last` in 1: qualifies the final byte of the image.
- `load_error` out 1: sticky; image exceeded `DEPTH`.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0] are ignored; no alignment trap.
- Out-of-range address (any of addr[31:log2(DEPTH)+2] nonzero):
  - read returns 0;
  - write is dropped.
- Reads on both ports are registered:
  - `instr_in` / `data_in` at edge N+1 reflect the array at the address presented before edge N+1.
  - Both update every cycle in RUN.
- Data write: in RUN, when `data_rd_wr`=0 at the edge, mem[idx(data_addr)] <= `data_out`.
- Read-during-write, same word, same edge:
  - the data port returns the old value (read-first);
  - the instruction port also returns the old value.
- State machine, states LOAD and RUN:
  - Reset: goes to LOAD if `BOOT_LOAD`=1, else RUN. The load address counter and byte counter are cleared.
  - LOAD:
    - `load_ready`=1; a byte is accepted when `load_valid` && `load_ready`.
    - Bytes are shifted into a 32-bit assembly register, byte k landing in bits [8k+7:8k].
    - On the 4th byte, the word is written to mem[waddr] and waddr increments.
    - On `load_last`, any partial word is written with the unfilled upper bytes = 0, then the FSM goes to RUN on the same edge.
  - Overflow: an accepted byte whose word would land at waddr ≥ `DEPTH` is discarded and sets `load_error`. Loading continues until `load_last`.
  - RUN: `load_ready`=0; `load_valid` is ignored.
  - `load_start`, in either state: go to LOAD, clear waddr, the byte counter and `load_error`. `load_start` has priority over a simultaneous accepted byte, which is dropped.
- `cpu_reset`:
  - 1 in LOAD, and for exactly one cycle after the LOAD→RUN edge;
  - 0 otherwise.
- In LOAD, core data writes are ignored. `instr_in` and `data_in` are held at 0.

## Timing
- Reset values: `instr_in`=0, `data_in`=0, `load_error`=0.
  - `cpu_reset`=1 and `load_ready`=1 if `BOOT_LOAD`=1.
  - `cpu_reset`=0 and `load_ready`=0 if `BOOT_LOAD`=0.
- Reset assertion mid-load:
  - the FSM state and counters return to their reset values immediately;
  - array contents are not cleared.
- Read latency: 1 cycle on both ports. Write is visible to a read at the next edge.
- Loader throughput: 1 byte per cycle; a word commit happens on the same edge as its 4th byte.
- LOAD→RUN: the edge that accepts the `load_last` byte.
  - `cpu_reset` falls one edge later.
  - The core's first fetch sees the fully written image.

## Structure
- Package `mips_pkg` holds:
  - `MEM_STATE` enum {LOAD, RUN};
  - the little-endian byte-lane constants.
- Sub-module `mips_ram`:
  - dual-port, `DEPTH`×32;
  - one read/write port (data, also used by the loader);
  - one read-only port (instruction);
  - read-first, registered outputs.
- The loader FSM and its byte assembly live in `mips_memory`. The loader write and the core write share the RAM write port, muxed by state.

## Test plan
- Reset with `BOOT_LOAD`=1:
  - stream bytes 0x78,0x56,0x34,0x12, then 0xEF,0xBE (`load_last`).
  - Expect mem[0]=0x12345678 and mem[1]=0x0000BEEF.
  - Expect `cpu_reset` to fall 2 edges after the last byte.
- RUN:
  - `data_rd_wr`=0, `data_addr`=0x10, `data_out`=0xCAFEF00D.
  - Then read 0x10 and 0x13: `data_in`=0xCAFEF00D, 1 cycle after each.
- Read-during-write:
  - write 0x1 to 0x20 while reading 0x20 on both ports in the same cycle.
  - Expect the old value that cycle and 0x1 on the next read.
- Out of range (`DEPTH`=1024):
  - read 0x1000 → 0;
  - write 0x1000 → mem[0] unchanged.
- Load of `DEPTH`+1 words:
  - `load_error`=1 and mem[0] intact.
  - A following `load_start` clears `load_error` and raises `cpu_reset`.
- Mid-load handling:
  - `reset` asserted mid-load: `load_error`=0, waddr restarts at 0.
  - `load_start` coinciding with a valid byte: that byte is dropped.
